chart_sequencer: RTL and testbench
==================================

# chart_sequencer

Song-level scheduler for the note-lane display. It paces reads from the chart ROM at a fixed number of video frames per chart step and drives the `note`/`valid_note` pair consumed by the lane renderer. It owns the song state machine: idle, count-in, play, pause, drain and done. It sits between the chart ROM and the screen generator and is started and paused from the active-low player buttons.

## Interface
- `ADDR_W`, 10: chart ROM address width.
- `CHART_LEN`, 1024: number of chart entries (1..2^ADDR_W).
- `FRAMES_PER_STEP`, 8: frame ticks per chart step (≥2).
- `COUNTDOWN_STEPS`, 4: empty steps before the first chart entry (≥1).
- `DRAIN_STEPS`, 16: empty steps after the last entry before done (≥1).

- `clk` input 1: system clock; one clock.
- `reset` input 1: asynchronous, active-high; clears all state.
- `frame_tick` input 1: one-cycle pulse per video frame, synchronous to `clk`.
- `start_n` input 1: start button, active-low, asynchronous.
- `pause_n` input 1: pause button, active-low, asynchronous.
- `chart_addr` output ADDR_W: chart ROM address (registered).
- `chart_data` input 8: ROM word, synchronous read with 1-cycle latency. Packing is [7:6] green, [5:4] yellow, [3:2] blue, [1:0] orange.
- `note` output 8: current step's lane codes, held for the whole step.
- `valid_note` output 1: one-cycle pulse whenever `note` is updated at a step boundary.
- `playing` output 1: high in COUNTDOWN, PLAYING and DRAIN.
- `paused` output 1: high in PAUSED.
- `song_done` output 1: high in DONE.

## Operation
- **Button conditioning.**
  - `start_n` and `pause_n` each pass through a 2-flop synchronizer.
  - A press event is the synchronized 1→0 transition, which produces a one-cycle internal pulse.
  - Holding a button gives exactly one event.
- **Step boundary.**
  - `frame_cnt` (clog2(FRAMES_PER_STEP) bits) increments on `frame_tick`.
  - `boundary` = `frame_tick` && `frame_cnt`==FRAMES_PER_STEP-1; `frame_cnt` wraps to 0 on that cycle.
  - `frame_cnt` advances only in COUNTDOWN, PLAYING and DRAIN. It is frozen in PAUSED and held at 0 in IDLE and DONE.
- **States and transitions.**
  - IDLE: on a start event, set `chart_addr`←0, `frame_cnt`←0, `step_cnt`←0, and go to COUNTDOWN.
  - COUNTDOWN: count boundaries in `step_cnt`.
    - On the COUNTDOWN_STEPS-th boundary: `note`←`chart_data` (entry 0), pulse `valid_note`, `chart_addr`←1, go to PLAYING.
    - If CHART_LEN==1, go directly to DRAIN instead.
  - PLAYING:
    - On each boundary: `note`←`chart_data`, pulse `valid_note`, `chart_addr`←`chart_addr`+1.
    - On the boundary that issues entry CHART_LEN-1: go to DRAIN, reset `step_cnt`. `chart_addr` is not incremented past CHART_LEN-1.
    - A pause event goes to PAUSED.
  - PAUSED:
    - `note` holds its value; no `valid_note`; `frame_tick` ignored.
    - A pause event returns to PLAYING with `frame_cnt` unchanged.
  - DRAIN:
    - On the first boundary: `note`←0 and pulse `valid_note`.
    - After DRAIN_STEPS boundaries: go to DONE.
    - Pause events are ignored.
  - DONE: a start event restarts exactly as from IDLE.
- **Outputs by state.** `note` is 0 in IDLE, COUNTDOWN and DONE. COUNTDOWN boundaries do not pulse `valid_note`.
- **Don't-care events.** A start event is ignored outside IDLE/DONE; a pause event is ignored outside PLAYING/PAUSED.

## Timing
- **Reset values:** state IDLE, `note`=0, `valid_note`=0, `chart_addr`=0, `playing`=0, `paused`=0, `song_done`=0, all counters 0, synchronizer flops 1 (released).
- **Button latency:** a button edge reaches the state change in 3 cycles (2 sync + 1 edge/state register).
- **Note output latency:** `note`/`valid_note` are registered and update on the clock after the boundary cycle.
- **ROM timing:** `chart_addr` changes on that same edge. The ROM has ≥FRAMES_PER_STEP frames to settle before the next sample, so no read stall is required.
- **Simultaneous events:**
  - A pause event and a boundary in the same cycle in PLAYING: pause wins; no note is issued and `frame_cnt` is not advanced.
  - A pause event and a boundary in the same cycle in PAUSED: resume only; that tick is not counted.
- **Wrap-around:** the `chart_addr` increment never wraps; CHART_LEN = 2^ADDR_W is legal.
- **Reset mid-song:** asynchronous return to IDLE; outputs take their reset values immediately.

## Test plan
Common setup: FRAMES_PER_STEP=2, COUNTDOWN_STEPS=2, CHART_LEN=4, DRAIN_STEPS=1; `frame_tick` every 10 cycles; ROM = {0x C0, 0x30, 0x0C, 0x03}.

1. **Full song.** Press start.
   - `playing`=1 after 3 cycles.
   - After 4 ticks, `note`=0xC0 with a `valid_note` pulse.
   - Then 0x30, 0x0C and 0x03, each 2 ticks apart.
   - Then `note`=0 with a pulse, then `song_done`=1 and `playing`=0.
2. **Pause mid-song.** Pause after the 0x30 step.
   - `paused`=1; `note` stays 0x30 for 10 ticks with no `valid_note`.
   - Press pause again: 0x0C appears after the remaining frame count (1 tick if paused mid-step).
3. **Pause collides with boundary.** Pause event coincides with a boundary `frame_tick`.
   - State goes to PAUSED; no note is issued; `chart_addr` is unchanged.
4. **Held and ignored buttons.**
   - Hold `start_n` low for 100 cycles: exactly one start.
   - Pause during COUNTDOWN or DRAIN: ignored.
   - Start during PLAYING: ignored.
5. **Async reset mid-song.** Assert `reset` mid-PLAYING between clock edges.
   - `note`=0, `chart_addr`=0 and state IDLE immediately.
   - A restart replays from entry 0.
6. **Restart and single-entry chart.**
   - Start from DONE: the sequence is identical to scenario 1.
   - With CHART_LEN=1: entry 0 is issued, then DRAIN, then DONE.

Source files
------------

// File: rtl/chart_sequencer.sv
// chart_sequencer: song-level scheduler for the note lanes.
// Paces chart ROM reads at FRAMES_PER_STEP frames per step, runs the
// idle/count-in/play/pause/drain/done song state machine and drives the
// registered note/valid_note pair for the lane renderer.
module chart_sequencer #(
   parameter int ADDR_W          = 10,
   parameter int CHART_LEN       = 1024,
   parameter int FRAMES_PER_STEP = 8,
   parameter int COUNTDOWN_STEPS = 4,
   parameter int DRAIN_STEPS     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_tick,
   input  logic              start_n,
   input  logic              pause_n,
   output logic [ADDR_W-1:0] chart_addr,
   input  logic [7:0]        chart_data,
   output logic [7:0]        note,
   output logic              valid_note,
   output logic              playing,
   output logic              paused,
   output logic              song_done
);

   localparam int FC_W     = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam int STEP_MAX = (COUNTDOWN_STEPS > DRAIN_STEPS) ? COUNTDOWN_STEPS : DRAIN_STEPS;
   localparam int SC_W     = $clog2(STEP_MAX + 1);

   localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(FRAMES_PER_STEP - 1);
   localparam logic [SC_W-1:0]   CD_LAST   = SC_W'(COUNTDOWN_STEPS - 1);
   localparam logic [SC_W-1:0]   DR_LAST   = SC_W'(DRAIN_STEPS - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(CHART_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_COUNTDOWN, S_PLAYING, S_PAUSED, S_DRAIN, S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [2:0]        start_sr_q, pause_sr_q;
   logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic [SC_W-1:0]   step_cnt_q, step_cnt_d;
   logic [ADDR_W-1:0] chart_addr_q, chart_addr_d;
   logic [7:0]        note_q, note_d;
   logic              valid_q, valid_d;

   logic start_evt, pause_evt, boundary, last_entry;

   // [1:0] are the synchronizer pair, [2] remembers the previous level so a
   // held button produces a single falling-edge event
   assign start_evt  = start_sr_q[2] & ~start_sr_q[1];
   assign pause_evt  = pause_sr_q[2] & ~pause_sr_q[1];
   assign boundary   = frame_tick && (frame_cnt_q == FC_LAST);
   assign last_entry = (chart_addr_q == ADDR_LAST);

   // Button synchronizers and edge-detect history, released level is 1
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_sr_q <= '1;
         pause_sr_q <= '1;
      end else begin
         start_sr_q <= {start_sr_q[1:0], start_n};
         pause_sr_q <= {pause_sr_q[1:0], pause_n};
      end
   end

   // Song state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; a pause event outranks a boundary in PLAYING
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (start_evt) state_d = S_COUNTDOWN;
         S_COUNTDOWN:
            if (boundary && step_cnt_q == CD_LAST)
               state_d = (CHART_LEN == 1) ? S_DRAIN : S_PLAYING;
         S_PLAYING:
            if (pause_evt)                    state_d = S_PAUSED;
            else if (boundary && last_entry)  state_d = S_DRAIN;
         S_PAUSED:  if (pause_evt) state_d = S_PLAYING;
         S_DRAIN:   if (boundary && step_cnt_q == DR_LAST) state_d = S_DONE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Status outputs decoded from the current state
   always_comb begin
      playing   = (state_q == S_COUNTDOWN) || (state_q == S_PLAYING) || (state_q == S_DRAIN);
      paused    = (state_q == S_PAUSED);
      song_done = (state_q == S_DONE);
   end

   // Datapath next values: frame/step counters, ROM address, note latch
   always_comb begin
      frame_cnt_d  = frame_cnt_q;
      step_cnt_d   = step_cnt_q;
      chart_addr_d = chart_addr_q;
      note_d       = note_q;
      valid_d      = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            frame_cnt_d = '0;
            if (start_evt) begin
               step_cnt_d   = '0;
               chart_addr_d = '0;
               note_d       = '0;
            end
         end
         S_COUNTDOWN: begin
            if (frame_tick) frame_cnt_d = boundary ? '0 : frame_cnt_q + 1'b1;
            if (boundary) begin
               if (step_cnt_q == CD_LAST) begin
                  // entry 0 has been on chart_data since the address was cleared
                  note_d       = chart_data;
                  valid_d      = 1'b1;
                  step_cnt_d   = '0;
                  chart_addr_d = last_entry ? chart_addr_q : chart_addr_q + 1'b1;
               end else begin
                  step_cnt_d = step_cnt_q + 1'b1;
               end
            end
         end
         S_PLAYING: begin
            if (!pause_evt) begin
               if (frame_tick) frame_cnt_d = boundary ? '0 : frame_cnt_q + 1'b1;
               if (boundary) begin
                  note_d  = chart_data;
                  valid_d = 1'b1;
                  // the address parks on the last entry, so it never wraps
                  if (last_entry) step_cnt_d   = '0;
                  else            chart_addr_d = chart_addr_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (frame_tick) frame_cnt_d = boundary ? '0 : frame_cnt_q + 1'b1;
            if (boundary) begin
               if (step_cnt_q == '0) begin
                  note_d  = '0;
                  valid_d = 1'b1;
               end
               step_cnt_d = step_cnt_q + 1'b1;
            end
         end
         default: ;  // PAUSED: everything frozen
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt_q  <= '0;
         step_cnt_q   <= '0;
         chart_addr_q <= '0;
         note_q       <= '0;
         valid_q      <= 1'b0;
      end else begin
         frame_cnt_q  <= frame_cnt_d;
         step_cnt_q   <= step_cnt_d;
         chart_addr_q <= chart_addr_d;
         note_q       <= note_d;
         valid_q      <= valid_d;
      end
   end

   assign chart_addr = chart_addr_q;
   assign note       = note_q;
   assign valid_note = valid_q;

endmodule

// File: tb/tb_chart_sequencer.sv
// Directed bench for chart_sequencer: a 4-entry chart instance driven from
// a vector table, plus hand sequences for async reset and a 1-entry chart.
module tb_chart_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_tick, start_n, pause_n;
   logic [9:0] addr1;
   logic [7:0] data1, note1;
   logic       valid1, playing1, paused1, done1;

   logic       tick2, start2_n, pause2_n;
   logic [9:0] addr2;
   logic [7:0] data2, note2;
   logic       valid2, playing2, paused2, done2;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   chart_sequencer #(.ADDR_W(10), .CHART_LEN(4), .FRAMES_PER_STEP(2),
                     .COUNTDOWN_STEPS(2), .DRAIN_STEPS(1)) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_n(start_n),
      .pause_n(pause_n), .chart_addr(addr1), .chart_data(data1), .note(note1),
      .valid_note(valid1), .playing(playing1), .paused(paused1), .song_done(done1));

   chart_sequencer #(.ADDR_W(10), .CHART_LEN(1), .FRAMES_PER_STEP(2),
                     .COUNTDOWN_STEPS(2), .DRAIN_STEPS(1)) dut1e (
      .clk(clk), .reset(reset), .frame_tick(tick2), .start_n(start2_n),
      .pause_n(pause2_n), .chart_addr(addr2), .chart_data(data2), .note(note2),
      .valid_note(valid2), .playing(playing2), .paused(paused2), .song_done(done2));

   // synchronous ROMs with one cycle of read latency
   always @(posedge clk) begin
      case (addr1)
         10'd0:   data1 <= 8'hC0;
         10'd1:   data1 <= 8'h30;
         10'd2:   data1 <= 8'h0C;
         10'd3:   data1 <= 8'h03;
         default: data1 <= 8'hEE;
      endcase
      data2 <= (addr2 == 10'd0) ? 8'hA5 : 8'hEE;
   end

   typedef struct {
      string       name;
      int          pre;
      bit          tk;
      int          post;
      int          rep;
      bit          s;
      bit          p;
      logic [21:0] exp;
   } vec_t;

   vec_t vq[$];

   function automatic logic [21:0] pk(logic [7:0] nt, bit v, bit pl, bit ps, bit dn, logic [9:0] ad);
      return {nt, v, pl, ps, dn, ad};
   endfunction

   function automatic void add(string n, int pre, bit tk, int post, int rep, bit s, bit p,
                               logic [7:0] nt, bit v, bit pl, bit ps, bit dn, logic [9:0] ad);
      vec_t e;
      e.name = n; e.pre = pre; e.tk = tk; e.post = post; e.rep = rep;
      e.s = s; e.p = p; e.exp = pk(nt, v, pl, ps, dn, ad);
      vq.push_back(e);
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string nm, logic [21:0] got, logic [21:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got note/v/pl/ps/dn/addr=%h want %h", nm, got, exp);
      end
   endtask

   function automatic logic [21:0] o1();
      return {note1, valid1, playing1, paused1, done1, addr1};
   endfunction

   function automatic logic [21:0] o2();
      return {note2, valid2, playing2, paused2, done2, addr2};
   endfunction

   task automatic press1();
      start_n = 1'b0;
      repeat (3) cyc();
      start_n = 1'b1;
   endtask

   task automatic tick1();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
   endtask

   task automatic tick_2();
      tick2 = 1'b1;
      cyc();
      tick2 = 1'b0;
   endtask

   initial begin
      reset = 1'b1; frame_tick = 1'b0; start_n = 1'b1; pause_n = 1'b1;
      tick2 = 1'b0; start2_n = 1'b1; pause2_n = 1'b1;

      //   name          pre tk post rep  s  p   note  v pl ps dn addr
      add("reset",        0, 0, 0,  1,   1, 1, 8'h00, 0, 0, 0, 0, 0);
      add("idle_tick",    0, 1, 9,  1,   1, 1, 8'h00, 0, 0, 0, 0, 0);
      add("start_2cy",    2, 0, 0,  1,   0, 1, 8'h00, 0, 0, 0, 0, 0);
      add("start_3cy",    1, 0, 0,  1,   0, 1, 8'h00, 0, 1, 0, 0, 0);
      add("cd_tick1",     0, 1, 9,  1,   0, 1, 8'h00, 0, 1, 0, 0, 0);
      add("cd_pause",     3, 0, 40, 1,   0, 0, 8'h00, 0, 1, 0, 0, 0);
      add("cd_tick2",     0, 1, 9,  1,   0, 1, 8'h00, 0, 1, 0, 0, 0);
      add("cd_tick3",     0, 1, 9,  1,   0, 1, 8'h00, 0, 1, 0, 0, 0);
      add("cd_tick4",     0, 1, 9,  1,   0, 1, 8'hC0, 1, 1, 0, 0, 1);
      add("pl_tick1",     0, 1, 9,  1,   0, 1, 8'hC0, 0, 1, 0, 0, 1);
      add("pl_tick2",     0, 1, 9,  1,   0, 1, 8'h30, 1, 1, 0, 0, 2);
      add("pl_tick3",     0, 1, 9,  1,   1, 1, 8'h30, 0, 1, 0, 0, 2);
      add("pl_start",     3, 0, 0,  1,   0, 1, 8'h30, 0, 1, 0, 0, 2);
      add("pause",        3, 0, 0,  1,   1, 0, 8'h30, 0, 0, 1, 0, 2);
      add("ps_tick",      0, 1, 9,  10,  1, 1, 8'h30, 0, 0, 1, 0, 2);
      add("resume",       3, 0, 0,  1,   1, 0, 8'h30, 0, 1, 0, 0, 2);
      add("pl_tick4",     0, 1, 9,  1,   1, 1, 8'h0C, 1, 1, 0, 0, 3);
      add("pl_tick5",     0, 1, 9,  1,   1, 1, 8'h0C, 0, 1, 0, 0, 3);
      add("pause_bnd",    2, 1, 9,  1,   1, 0, 8'h0C, 0, 0, 1, 0, 3);
      add("ps_tick2",     0, 1, 9,  2,   1, 1, 8'h0C, 0, 0, 1, 0, 3);
      add("resume_bnd",   2, 1, 9,  1,   1, 0, 8'h0C, 0, 1, 0, 0, 3);
      add("pl_tick6",     0, 1, 9,  1,   1, 1, 8'h03, 1, 1, 0, 0, 3);
      add("dr_pause",     3, 0, 0,  1,   1, 0, 8'h03, 0, 1, 0, 0, 3);
      add("dr_tick1",     0, 1, 9,  1,   1, 1, 8'h03, 0, 1, 0, 0, 3);
      add("dr_tick2",     0, 1, 9,  1,   1, 1, 8'h00, 1, 0, 0, 1, 3);
      add("done_tick",    0, 1, 9,  2,   1, 1, 8'h00, 0, 0, 0, 1, 3);
      add("re_2cy",       2, 0, 0,  1,   0, 1, 8'h00, 0, 0, 0, 1, 3);
      add("re_3cy",       1, 0, 0,  1,   0, 1, 8'h00, 0, 1, 0, 0, 0);
      add("re_cd",        0, 1, 9,  3,   0, 1, 8'h00, 0, 1, 0, 0, 0);
      add("re_e0",        0, 1, 9,  1,   0, 1, 8'hC0, 1, 1, 0, 0, 1);
      add("re_h0",        0, 1, 9,  1,   0, 1, 8'hC0, 0, 1, 0, 0, 1);
      add("re_e1",        0, 1, 9,  1,   0, 1, 8'h30, 1, 1, 0, 0, 2);
      add("re_h1",        0, 1, 9,  1,   0, 1, 8'h30, 0, 1, 0, 0, 2);
      add("re_e2",        0, 1, 9,  1,   0, 1, 8'h0C, 1, 1, 0, 0, 3);
      add("re_h2",        0, 1, 9,  1,   0, 1, 8'h0C, 0, 1, 0, 0, 3);
      add("re_e3",        0, 1, 9,  1,   0, 1, 8'h03, 1, 1, 0, 0, 3);
      add("re_h3",        0, 1, 9,  1,   0, 1, 8'h03, 0, 1, 0, 0, 3);
      add("re_end",       0, 1, 9,  1,   0, 1, 8'h00, 1, 0, 0, 1, 3);
      add("done_held",    20, 0, 0, 1,   0, 1, 8'h00, 0, 0, 0, 1, 3);

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      foreach (vq[i]) begin
         for (int r = 0; r < vq[i].rep; r++) begin
            start_n = vq[i].s;
            pause_n = vq[i].p;
            repeat (vq[i].pre) cyc();
            if (vq[i].tk) tick1();
            chk(vq[i].name, o1(), vq[i].exp);
            repeat (vq[i].post) cyc();
         end
      end

      // async reset in the middle of PLAYING, then replay from entry 0
      start_n = 1'b1; pause_n = 1'b1;
      repeat (5) cyc();
      press1();
      chk("rs_start", o1(), pk(8'h00, 0, 1, 0, 0, 0));
      for (int k = 0; k < 4; k++) begin
         tick1();
         repeat (9) cyc();
      end
      tick1();
      chk("rs_play", o1(), pk(8'hC0, 0, 1, 0, 0, 1));
      #3 reset = 1'b1;
      #1 chk("async_rst", o1(), pk(8'h00, 0, 0, 0, 0, 0));
      cyc();
      reset = 1'b0;
      tick1();
      chk("rst_idle", o1(), pk(8'h00, 0, 0, 0, 0, 0));
      repeat (9) cyc();
      press1();
      for (int k = 0; k < 3; k++) begin
         tick1();
         repeat (9) cyc();
      end
      tick1();
      chk("rst_replay", o1(), pk(8'hC0, 1, 1, 0, 0, 1));
      cyc();
      chk("pulse_width", o1(), pk(8'hC0, 0, 1, 0, 0, 1));

      // single-entry chart: entry 0, then drain, then done
      start2_n = 1'b0;
      repeat (3) cyc();
      start2_n = 1'b1;
      chk("one_start", o2(), pk(8'h00, 0, 1, 0, 0, 0));
      for (int k = 0; k < 3; k++) begin
         tick_2();
         repeat (9) cyc();
      end
      tick_2();
      chk("one_entry", o2(), pk(8'hA5, 1, 1, 0, 0, 0));
      repeat (9) cyc();
      tick_2();
      chk("one_hold", o2(), pk(8'hA5, 0, 1, 0, 0, 0));
      repeat (9) cyc();
      tick_2();
      chk("one_done", o2(), pk(8'h00, 1, 0, 0, 1, 0));
      repeat (3) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
